memory_cycle: RTL and testbench

- Memory stage of the 16-bit five-stage pipeline. Sits between the execute stage and the write-back stage.
- Issues loads and stores to the data memory over a req/ack handshake and stalls upstream while an access is outstanding.
- Owns the MEM/WB pipeline register that feeds write-back with control, ALU result, read data, destination register and pc+4.
- Contains a bus-timeout watchdog.

---
 rtl/memory_cycle_pkg.sv | 23 ++
 rtl/memory_cycle_if.sv | 34 +++
 rtl/memory_cycle_mem_wb_reg.sv | 51 +++++
 rtl/memory_cycle.sv | 174 +++++++++++++++++
 tb/tb_memory_cycle.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_cycle_pkg.sv
// Shared encodings and default widths for the memory stage.
// No logic; imported by the interface, the MEM/WB register and the stage top.
package memory_cycle_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_AW = 3;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // A load is recognised only by the 01 encoding, so 11 falls through as a plain ALU op.
    function automatic logic isMemOp(input logic valid, input logic memWrite,
                                     input logic [1:0] resultSrc);
        return valid & (memWrite | (resultSrc == RES_MEM));
    endfunction

endpackage

// File: rtl/memory_cycle_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
// Latency: none (wires only); backpressure: master holds the request until ack.
interface memory_cycle_if
    import memory_cycle_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) ();

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/memory_cycle_mem_wb_reg.sv
// MEM/WB pipeline register: load captures a full slot, otherwise a bubble is written.
// Latency: 1 cycle; backpressure: none, every edge is either a load or a bubble.
module mem_wb_reg
    import memory_cycle_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          regwrite,
    input  logic [1:0]    resultSrc,
    input  logic [DW-1:0] aluResult,
    input  logic [DW-1:0] readData,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] pcPlus4,
    output logic          RegwriteW,
    output logic [1:0]    ResultSrcW,
    output logic [DW-1:0] ALUResultW,
    output logic [DW-1:0] ReadDataW,
    output logic [AW-1:0] RdW,
    output logic [DW-1:0] pc_plus4W,
    output logic          validW
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegwriteW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            pc_plus4W  <= '0;
            validW     <= 1'b0;
        end else if (load) begin
            RegwriteW  <= regwrite;
            ResultSrcW <= resultSrc;
            ALUResultW <= aluResult;
            ReadDataW  <= readData;
            RdW        <= rd;
            pc_plus4W  <= pcPlus4;
            validW     <= 1'b1;
        end else begin
            // Bubble: only the qualifiers are cleared, data fields keep their last values.
            RegwriteW  <= 1'b0;
            validW     <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: issues loads/stores on a req/ack bus, watchdogs the access, feeds MEM/WB.
// Latency: 1 cycle for ALU ops, >=2 for memory ops; backpressure: stallM holds upstream.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int AW      = DEFAULT_AW,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validM,
    input  logic          RegwriteM,
    input  logic          MemWriteM,
    input  logic [1:0]    ResultSrcM,
    input  logic [DW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic [AW-1:0] RdM,
    input  logic [DW-1:0] pc_plus4M,
    output logic          stallM,
    memory_cycle_if.master dmem,
    output logic          RegwriteW,
    output logic [1:0]    ResultSrcW,
    output logic [DW-1:0] ALUResultW,
    output logic [DW-1:0] ReadDataW,
    output logic [AW-1:0] RdW,
    output logic [DW-1:0] pc_plus4W,
    output logic          validW,
    output logic          mem_err
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic          regwrite;
        logic [1:0]    resultSrc;
        logic [DW-1:0] aluResult;
        logic [AW-1:0] rd;
        logic [DW-1:0] pcPlus4;
        logic          we;
    } pend_t;

    state_t        state;
    state_t        nextState;
    pend_t         pend;
    logic [7:0]    count;
    logic          memop;
    logic          issue;
    logic          finish;
    logic          timeoutHit;
    logic          loadW;
    logic          wbRegwrite;
    logic [1:0]    wbResultSrc;
    logic [DW-1:0] wbAluResult;
    logic [DW-1:0] wbReadData;
    logic [AW-1:0] wbRd;
    logic [DW-1:0] wbPcPlus4;

    assign memop = isMemOp(validM, MemWriteM, ResultSrcM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        stallM      = 1'b0;
        issue       = 1'b0;
        finish      = 1'b0;
        timeoutHit  = 1'b0;
        loadW       = 1'b0;
        wbRegwrite  = RegwriteM;
        wbResultSrc = ResultSrcM;
        wbAluResult = ALUResultM;
        wbReadData  = '0;
        wbRd        = RdM;
        wbPcPlus4   = pc_plus4M;
        case (state)
            S_IDLE: begin
                if (memop) begin
                    stallM    = 1'b1;
                    issue     = 1'b1;
                    nextState = S_WAIT;
                end else begin
                    loadW = validM;
                end
            end
            S_WAIT: begin
                wbRegwrite  = pend.regwrite;
                wbResultSrc = pend.resultSrc;
                wbAluResult = pend.aluResult;
                wbRd        = pend.rd;
                wbPcPlus4   = pend.pcPlus4;
                timeoutHit  = ~dmem.dmem_ack & (count == LAST_COUNT);
                // An ack arriving on the timeout cycle still completes normally.
                if (dmem.dmem_ack) begin
                    finish     = 1'b1;
                    loadW      = 1'b1;
                    wbReadData = pend.we ? '0 : dmem.dmem_rdata;
                    nextState  = S_IDLE;
                end else if (timeoutHit) begin
                    finish     = 1'b1;
                    loadW      = 1'b1;
                    wbRegwrite = 1'b0;
                    nextState  = S_IDLE;
                end else begin
                    stallM = 1'b1;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            pend            <= '0;
            count           <= '0;
            mem_err         <= 1'b0;
        end else begin
            if (issue) begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= MemWriteM;
                dmem.dmem_addr  <= ALUResultM;
                dmem.dmem_wdata <= WriteDataM;
                pend.regwrite   <= RegwriteM;
                pend.resultSrc  <= ResultSrcM;
                pend.aluResult  <= ALUResultM;
                pend.rd         <= RdM;
                pend.pcPlus4    <= pc_plus4M;
                pend.we         <= MemWriteM;
                count           <= '0;
            end else if (finish) begin
                dmem.dmem_req <= 1'b0;
                dmem.dmem_we  <= 1'b0;
            end else if (state == S_WAIT) begin
                count <= count + 8'd1;
            end
            if (timeoutHit) begin
                mem_err <= 1'b1;
            end
        end
    end

    mem_wb_reg #(
        .DW(DW),
        .AW(AW)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (loadW),
        .regwrite  (wbRegwrite),
        .resultSrc (wbResultSrc),
        .aluResult (wbAluResult),
        .readData  (wbReadData),
        .rd        (wbRd),
        .pcPlus4   (wbPcPlus4),
        .RegwriteW (RegwriteW),
        .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .RdW       (RdW),
        .pc_plus4W (pc_plus4W),
        .validW    (validW)
    );

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed cases then random instructions with random ack delays,
// each instruction's expected W slot derived from its fields and its ack delay.
module tb_memory_cycle;
    import memory_cycle_pkg::*;

    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int TIMEOUT = 15;
    localparam int NO_ACK  = 1000;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memWrite;
        logic [1:0]    resultSrc;
        logic [DW-1:0] aluResult;
        logic [DW-1:0] writeData;
        logic [AW-1:0] rd;
        logic [DW-1:0] pcPlus4;
    } instr_t;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic [1:0]    resultSrc;
        logic [DW-1:0] aluResult;
        logic [DW-1:0] readData;
        logic [AW-1:0] rd;
        logic [DW-1:0] pcPlus4;
    } wb_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          validM;
    logic          RegwriteM;
    logic          MemWriteM;
    logic [1:0]    ResultSrcM;
    logic [DW-1:0] ALUResultM;
    logic [DW-1:0] WriteDataM;
    logic [AW-1:0] RdM;
    logic [DW-1:0] pc_plus4M;
    logic          stallM;
    logic          RegwriteW;
    logic [1:0]    ResultSrcW;
    logic [DW-1:0] ALUResultW;
    logic [DW-1:0] ReadDataW;
    logic [AW-1:0] RdW;
    logic [DW-1:0] pc_plus4W;
    logic          validW;
    logic          mem_err;

    wb_t  expW;
    logic readKnown;
    logic memErrExp;
    int   nChecks = 0;
    int   nErrors = 0;

    always #5 clk = ~clk;

    memory_cycle_if #(.DW(DW)) dmemIf ();

    memory_cycle #(
        .DW(DW),
        .AW(AW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .validM    (validM),
        .RegwriteM (RegwriteM),
        .MemWriteM (MemWriteM),
        .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .RdM       (RdM),
        .pc_plus4M (pc_plus4M),
        .stallM    (stallM),
        .dmem      (dmemIf),
        .RegwriteW (RegwriteW),
        .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW),
        .ReadDataW (ReadDataW),
        .RdW       (RdW),
        .pc_plus4W (pc_plus4W),
        .validW    (validW),
        .mem_err   (mem_err)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkW(input string tag);
        checkVal({tag, ".validW"},     32'(validW),     32'(expW.valid));
        checkVal({tag, ".RegwriteW"},  32'(RegwriteW),  32'(expW.regwrite));
        checkVal({tag, ".ResultSrcW"}, 32'(ResultSrcW), 32'(expW.resultSrc));
        checkVal({tag, ".ALUResultW"}, 32'(ALUResultW), 32'(expW.aluResult));
        checkVal({tag, ".RdW"},        32'(RdW),        32'(expW.rd));
        checkVal({tag, ".pc_plus4W"},  32'(pc_plus4W),  32'(expW.pcPlus4));
        if (readKnown) checkVal({tag, ".ReadDataW"}, 32'(ReadDataW), 32'(expW.readData));
        checkVal({tag, ".mem_err"},    32'(mem_err),    32'(memErrExp));
    endtask

    task automatic applyInstr(input instr_t i);
        validM     = i.valid;
        RegwriteM  = i.regwrite;
        MemWriteM  = i.memWrite;
        ResultSrcM = i.resultSrc;
        ALUResultM = i.aluResult;
        WriteDataM = i.writeData;
        RdM        = i.rd;
        pc_plus4M  = i.pcPlus4;
    endtask

    function automatic instr_t randInstr();
        instr_t r;
        r.valid     = ($urandom_range(0, 99) < 85);
        r.regwrite  = 1'($urandom);
        r.memWrite  = ($urandom_range(0, 3) == 0);
        r.resultSrc = 2'($urandom_range(0, 2));
        r.aluResult = DW'($urandom);
        r.writeData = DW'($urandom);
        r.rd        = AW'($urandom);
        r.pcPlus4   = DW'($urandom);
        return r;
    endfunction

    function automatic instr_t mkInstr(input logic regwrite, input logic memWrite,
                                       input logic [1:0] resultSrc, input logic [DW-1:0] alu,
                                       input logic [DW-1:0] wdata, input logic [AW-1:0] rd,
                                       input logic [DW-1:0] pc4);
        instr_t r;
        r = '{valid: 1'b1, regwrite: regwrite, memWrite: memWrite, resultSrc: resultSrc,
              aluResult: alu, writeData: wdata, rd: rd, pcPlus4: pc4};
        return r;
    endfunction

    // Called one time unit after a rising edge; returns at the same phase after the op retires.
    task automatic runInstr(input string tag, input instr_t ins, input int ackDelay,
                            input logic [DW-1:0] ackData, input logic idleNoise);
        logic isMem;
        logic acked;
        int   stallCycles;
        isMem = ins.valid && (ins.memWrite || ins.resultSrc == RES_MEM);
        applyInstr(ins);
        dmemIf.dmem_ack   = idleNoise ? 1'($urandom) : 1'b0;
        dmemIf.dmem_rdata = DW'($urandom);
        #1;
        checkVal({tag, ".stall_first"}, 32'(stallM), 32'(isMem));
        @(posedge clk);
        #1;
        dmemIf.dmem_ack = 1'b0;
        if (!isMem) begin
            if (ins.valid) begin
                expW = '{valid: 1'b1, regwrite: ins.regwrite, resultSrc: ins.resultSrc,
                         aluResult: ins.aluResult, readData: '0, rd: ins.rd, pcPlus4: ins.pcPlus4};
                readKnown = 1'b0;
            end else begin
                expW.valid    = 1'b0;
                expW.regwrite = 1'b0;
            end
            checkW({tag, ".pass"});
            checkVal({tag, ".req_idle"}, 32'(dmemIf.dmem_req), 32'd0);
            return;
        end
        expW.valid    = 1'b0;
        expW.regwrite = 1'b0;
        checkW({tag, ".issue"});
        checkVal({tag, ".req"},   32'(dmemIf.dmem_req),   32'd1);
        checkVal({tag, ".we"},    32'(dmemIf.dmem_we),    32'(ins.memWrite));
        checkVal({tag, ".addr"},  32'(dmemIf.dmem_addr),  32'(ins.aluResult));
        if (ins.memWrite) checkVal({tag, ".wdata"}, 32'(dmemIf.dmem_wdata), 32'(ins.writeData));
        stallCycles = 1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            applyInstr(randInstr());
            acked = (k == ackDelay);
            dmemIf.dmem_ack   = acked;
            dmemIf.dmem_rdata = acked ? ackData : DW'($urandom);
            #1;
            checkVal({tag, ".stall_wait"}, 32'(stallM), 32'(!(acked || k == TIMEOUT)));
            if (stallM) stallCycles++;
            @(posedge clk);
            #1;
            dmemIf.dmem_ack = 1'b0;
            if (acked || k == TIMEOUT) begin
                expW = '{valid: 1'b1, regwrite: acked ? ins.regwrite : 1'b0,
                         resultSrc: ins.resultSrc, aluResult: ins.aluResult,
                         readData: (acked && !ins.memWrite) ? ackData : '0,
                         rd: ins.rd, pcPlus4: ins.pcPlus4};
                readKnown = 1'b1;
                if (!acked) memErrExp = 1'b1;
                checkW({tag, ".done"});
                checkVal({tag, ".req_drop"}, 32'(dmemIf.dmem_req), 32'd0);
                checkVal({tag, ".stall_count"}, 32'(stallCycles),
                         32'(acked ? ackDelay : TIMEOUT));
                break;
            end
            checkW({tag, ".bubble"});
            checkVal({tag, ".req_hold"},  32'(dmemIf.dmem_req),  32'd1);
            checkVal({tag, ".addr_hold"}, 32'(dmemIf.dmem_addr), 32'(ins.aluResult));
        end
    endtask

    initial begin
        instr_t ins;
        rst = 1'b1;
        applyInstr('0);
        dmemIf.dmem_ack   = 1'b0;
        dmemIf.dmem_rdata = '0;
        expW      = '0;
        readKnown = 1'b1;
        memErrExp = 1'b0;
        #1;
        checkW("reset");
        checkVal("reset.req",   32'(dmemIf.dmem_req), 32'd0);
        checkVal("reset.we",    32'(dmemIf.dmem_we),  32'd0);
        checkVal("reset.stall", 32'(stallM),          32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        runInstr("alu", mkInstr(1'b1, 1'b0, RES_ALU, 16'h1234, 16'h0, 3'd3, 16'h0), 0, '0, 1'b0);
        runInstr("load3", mkInstr(1'b1, 1'b0, RES_MEM, 16'h0040, 16'h0, 3'd5, 16'h0), 3,
                 16'hBEEF, 1'b0);
        runInstr("store1", mkInstr(1'b0, 1'b1, RES_ALU, 16'h0010, 16'h00AA, 3'd1, 16'h0), 1,
                 16'h5555, 1'b0);
        runInstr("timeout", mkInstr(1'b1, 1'b0, RES_MEM, 16'h0020, 16'h0, 3'd6, 16'h0), NO_ACK,
                 '0, 1'b0);
        runInstr("after_to", mkInstr(1'b1, 1'b0, RES_ALU, 16'h4321, 16'h0, 3'd2, 16'h0), 0,
                 '0, 1'b1);
        runInstr("b2b_load", mkInstr(1'b1, 1'b0, RES_MEM, 16'h0042, 16'h0, 3'd4, 16'h0), 2,
                 16'hCAFE, 1'b0);
        runInstr("b2b_link", mkInstr(1'b1, 1'b0, RES_PC4, 16'h0077, 16'h0, 3'd7, 16'h0008), 0,
                 '0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ins = randInstr();
            runInstr("rand", ins, $urandom_range(1, TIMEOUT + 3), DW'($urandom),
                     ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of an outstanding load.
        applyInstr(mkInstr(1'b1, 1'b0, RES_MEM, 16'h0080, 16'h0, 3'd1, 16'h0));
        @(posedge clk);
        #1;
        applyInstr('0);
        checkVal("rstmid.req_before", 32'(dmemIf.dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        expW      = '0;
        readKnown = 1'b1;
        memErrExp = 1'b0;
        checkW("rstmid.async");
        checkVal("rstmid.req",   32'(dmemIf.dmem_req), 32'd0);
        checkVal("rstmid.stall", 32'(stallM),          32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dmemIf.dmem_ack   = 1'b1;
        dmemIf.dmem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        dmemIf.dmem_ack = 1'b0;
        checkW("late_ack");
        checkVal("late_ack.req", 32'(dmemIf.dmem_req), 32'd0);
        runInstr("post_rst", mkInstr(1'b1, 1'b0, RES_ALU, 16'h0BAD, 16'h0, 3'd3, 16'h0), 0,
                 '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
